hdmi_link_sequencer: RTL
========================

# hdmi_link_sequencer

Power-up and recovery sequencer for the 720p HDMI output path. It runs on the board reference clock and drives the TMDS PLL reset. It then releases, in order, the 5x-to-1x clock divider reset, the HDMI core reset and the TMDS output enable. It gates the whole link on debounced hot-plug detect, retries PLL lock a bounded number of times, and restarts the chain on lock loss.

## Interface
Parameters:
- PLL_RST_CYCLES, 16: cycles `pll_reset` is held high per attempt.
- LOCK_TIMEOUT, 27000: maximum cycles spent in WAIT_LOCK per attempt.
- LOCK_STABLE_CYCLES, 256: consecutive synchronized-lock cycles required before release.
- DIV_DELAY_CYCLES, 8: cycles between divider release and core release.
- CORE_DELAY_CYCLES, 8: cycles between core release and RUN.
- HPD_DEBOUNCE, 2700: consecutive stable cycles required to change `hpd_db`.
- MAX_RETRIES, 3: lock timeouts tolerated before FAULT.

Ports:
- clk, in, 1: reference clock; the only clock in the block.
- resetn, in, 1: synchronous, active-low reset.
- pll_lock, in, 1: PLL lock; asynchronous, synchronized by 2 flops.
- hpd, in, 1: hot-plug detect; asynchronous, synchronized by 2 flops, then debounced.
- pll_reset, out, 1: active-high PLL reset.
- div_resetn, out, 1: clock divider reset, active low.
- core_resetn, out, 1: HDMI core reset, active low.
- tmds_oe, out, 1: TMDS output enable.
- link_up, out, 1: high only in RUN.
- fault, out, 1: high only in FAULT.
- retry_count, out, 4: lock timeouts in the current bring-up; saturates at 15.
- state, out, 3: current state encoding, for debug.

## Operation
- States and encodings: IDLE=0, PLL_RST=1, WAIT_LOCK=2, STABLE=3, DIV_REL=4, CORE_REL=5, RUN=6, FAULT=7.
- One shared down/up counter is cleared on every state transition.
- Outputs are registered and decoded from the state register. Values per state as (pll_reset, div_resetn, core_resetn, tmds_oe):
  - IDLE and PLL_RST: 1,0,0,0
  - WAIT_LOCK and STABLE: 0,0,0,0
  - DIV_REL: 0,1,0,0
  - CORE_REL: 0,1,1,0
  - RUN: 0,1,1,1
  - FAULT: 1,0,0,0
- IDLE → PLL_RST on the first cycle `hpd_db`=1.
- PLL_RST → WAIT_LOCK after exactly PLL_RST_CYCLES cycles.
- WAIT_LOCK:
  - `lock_s`=1 → STABLE.
  - Timeout after LOCK_TIMEOUT cycles: if `retry_count`==MAX_RETRIES → FAULT; otherwise increment `retry_count` and go to PLL_RST.
- STABLE:
  - `lock_s`=0 → WAIT_LOCK with a fresh timeout; this does not count as a retry.
  - After LOCK_STABLE_CYCLES consecutive cycles with `lock_s`=1 → DIV_REL.
- DIV_REL → CORE_REL after DIV_DELAY_CYCLES. CORE_REL → RUN after CORE_DELAY_CYCLES.
- `retry_count` clears on entry to RUN and on entry to IDLE.
- In DIV_REL, CORE_REL and RUN, `lock_s`=0 → PLL_RST; `retry_count` is unchanged.
- FAULT is held until `hpd_db`=0 (unplug), which moves to IDLE. Only a replug starts a new bring-up.
- Priority when events coincide: resetn, then `hpd_db`=0 (→ IDLE from any state except IDLE), then lock loss, then counter expiry.
- Debounce: `hpd_db` takes the synchronized value after that value differs from `hpd_db` for HPD_DEBOUNCE consecutive cycles. Any glitch restarts the count.
- Counter width is sized for the largest parameter; no wrap occurs within any state.

## Timing
- Reset values:
  - state=IDLE, pll_reset=1, div_resetn=0, core_resetn=0, tmds_oe=0.
  - link_up=0, fault=0, retry_count=0, counter=0.
  - Sync flops=0, hpd_db=0.
- Input latency: a `pll_lock` edge reaches `lock_s` 2 cycles later. A raw `hpd` edge reaches `hpd_db` 2+HPD_DEBOUNCE cycles later, provided the input stays stable.
- The state register and all outputs change on the same clock edge.
- Lock loss in RUN: `tmds_oe`=0, `core_resetn`=0, `div_resetn`=0 and `pll_reset`=1 all take effect on the edge after `lock_s` falls.
- resetn low in any state returns every output to its reset value on the next edge.

## Test plan
Parameters for all scenarios: PLL_RST=4, TIMEOUT=20, STABLE=8, DIV=2, CORE=2, DEBOUNCE=3, MAX_RETRIES=2. The PLL model raises lock 5 cycles after `pll_reset` falls and drops it while `pll_reset`=1.

- Nominal bring-up: `hpd`=1 held → states go 1→2→3→4→5→6. Dwell times: PLL_RST 4, STABLE 8, DIV_REL 2, CORE_REL 2. `tmds_oe`=1 and `link_up`=1 in RUN; `retry_count`=0.
- Lock never asserts → three WAIT_LOCK timeouts; `retry_count` steps 1, 2; third timeout → FAULT with `fault`=1 and `pll_reset`=1. Dropping `hpd` → IDLE with `retry_count`=0.
- Lock glitch (low for 1 cycle) in the middle of STABLE → return to WAIT_LOCK, then a full 8-cycle STABLE before DIV_REL. `retry_count` stays 0.
- Lock drop in RUN → all four outputs return to the PLL_RST values on the next edge. Bring-up then completes again automatically.
- `hpd` pulses of 2 cycles → `hpd_db` stays 0 and state stays IDLE. `hpd` low for 3+ cycles during CORE_REL → IDLE, overriding a simultaneous counter expiry.
- resetn asserted during RUN → all outputs take their reset values on the next edge; state=0.

Source files
------------

// File: rtl/hdmi_link_sequencer.sv
`timescale 1ns / 1ps
// HDMI link power-up / recovery sequencer.
// Holds the TMDS PLL in reset until a debounced hot-plug is seen, then releases
// the divider, the HDMI core and the TMDS drivers in order. It retries PLL lock
// a bounded number of times and restarts the chain whenever lock is lost.
module hdmi_link_sequencer #(
  parameter int unsigned PLL_RST_CYCLES     = 16,
  parameter int unsigned LOCK_TIMEOUT       = 27000,
  parameter int unsigned LOCK_STABLE_CYCLES = 256,
  parameter int unsigned DIV_DELAY_CYCLES   = 8,
  parameter int unsigned CORE_DELAY_CYCLES  = 8,
  parameter int unsigned HPD_DEBOUNCE       = 2700,
  parameter int unsigned MAX_RETRIES        = 3
) (
  input  logic       clk,
  input  logic       resetn,
  input  logic       pll_lock,
  input  logic       hpd,
  output logic       pll_reset,
  output logic       div_resetn,
  output logic       core_resetn,
  output logic       tmds_oe,
  output logic       link_up,
  output logic       fault,
  output logic [3:0] retry_count,
  output logic [2:0] state
);

  // Shared dwell counter is sized for the longest timed state.
  localparam int unsigned Max01 =
      (PLL_RST_CYCLES > LOCK_TIMEOUT) ? PLL_RST_CYCLES : LOCK_TIMEOUT;
  localparam int unsigned Max23 =
      (DIV_DELAY_CYCLES > CORE_DELAY_CYCLES) ? DIV_DELAY_CYCLES : CORE_DELAY_CYCLES;
  localparam int unsigned Max012 = (Max01 > LOCK_STABLE_CYCLES) ? Max01 : LOCK_STABLE_CYCLES;
  localparam int unsigned MaxCycles = (Max012 > Max23) ? Max012 : Max23;
  localparam int unsigned CntW = $clog2(MaxCycles + 1);
  localparam int unsigned DbW  = $clog2(HPD_DEBOUNCE + 1);

  // Terminal counts: a state with N cycles of dwell leaves when the counter reads N-1.
  localparam logic [CntW-1:0] PllRstLast  = CntW'(PLL_RST_CYCLES - 1);
  localparam logic [CntW-1:0] TimeoutLast = CntW'(LOCK_TIMEOUT - 1);
  localparam logic [CntW-1:0] StableLast  = CntW'(LOCK_STABLE_CYCLES - 1);
  localparam logic [CntW-1:0] DivLast     = CntW'(DIV_DELAY_CYCLES - 1);
  localparam logic [CntW-1:0] CoreLast    = CntW'(CORE_DELAY_CYCLES - 1);
  localparam logic [DbW-1:0]  DbLast      = DbW'(HPD_DEBOUNCE - 1);

  // A retry limit beyond the 4-bit counter range clamps to the saturation value.
  localparam logic [3:0] RetryLimit = (MAX_RETRIES > 15) ? 4'hf : 4'(MAX_RETRIES);

  typedef enum logic [2:0] {
    StIdle     = 3'd0,
    StPllRst   = 3'd1,
    StWaitLock = 3'd2,
    StStable   = 3'd3,
    StDivRel   = 3'd4,
    StCoreRel  = 3'd5,
    StRun      = 3'd6,
    StFault    = 3'd7
  } state_e;

  state_e          state_q, state_d;
  logic [CntW-1:0] cnt_q, cnt_d;
  logic [3:0]      retry_q, retry_d;

  logic            lock_meta_q, lock_s_q;
  logic            hpd_meta_q, hpd_s_q;
  logic            hpd_db_q;
  logic [DbW-1:0]  db_cnt_q;

  logic pll_reset_d, div_resetn_d, core_resetn_d, tmds_oe_d, link_up_d, fault_d;

  // Two-flop synchronizers for the asynchronous lock and hot-plug inputs.
  always_ff @(posedge clk) begin
    if (!resetn) begin
      lock_meta_q <= 1'b0;
      lock_s_q    <= 1'b0;
      hpd_meta_q  <= 1'b0;
      hpd_s_q     <= 1'b0;
    end else begin
      lock_meta_q <= pll_lock;
      lock_s_q    <= lock_meta_q;
      hpd_meta_q  <= hpd;
      hpd_s_q     <= hpd_meta_q;
    end
  end

  // Hot-plug debounce: adopt the synchronized level only after it has differed
  // from the current debounced level for HPD_DEBOUNCE consecutive cycles.
  always_ff @(posedge clk) begin
    if (!resetn) begin
      hpd_db_q <= 1'b0;
      db_cnt_q <= '0;
    end else if (hpd_s_q != hpd_db_q) begin
      if (db_cnt_q == DbLast) begin
        hpd_db_q <= hpd_s_q;
        db_cnt_q <= '0;
      end else begin
        db_cnt_q <= db_cnt_q + 1'b1;
      end
    end else begin
      db_cnt_q <= '0;
    end
  end

  // Next-state, retry bookkeeping and dwell counter.
  always_comb begin
    state_d = state_q;
    retry_d = retry_q;
    cnt_d   = '0;

    unique case (state_q)
      StIdle: begin
        if (hpd_db_q) state_d = StPllRst;
      end
      StPllRst: begin
        if (cnt_q == PllRstLast) state_d = StWaitLock;
      end
      StWaitLock: begin
        if (lock_s_q) begin
          state_d = StStable;
        end else if (cnt_q == TimeoutLast) begin
          if (retry_q == RetryLimit) begin
            state_d = StFault;
          end else begin
            state_d = StPllRst;
            if (retry_q != 4'hf) retry_d = retry_q + 4'd1;
          end
        end
      end
      StStable: begin
        // Any dropout restarts the lock wait; it is not charged as a retry.
        if (!lock_s_q)                state_d = StWaitLock;
        else if (cnt_q == StableLast) state_d = StDivRel;
      end
      StDivRel: begin
        if (!lock_s_q)             state_d = StPllRst;
        else if (cnt_q == DivLast) state_d = StCoreRel;
      end
      StCoreRel: begin
        if (!lock_s_q)              state_d = StPllRst;
        else if (cnt_q == CoreLast) state_d = StRun;
      end
      StRun: begin
        if (!lock_s_q) state_d = StPllRst;
      end
      StFault: begin
        // Parked until unplug; handled by the hot-plug override below.
      end
      default: state_d = StIdle;
    endcase

    // Unplug beats lock loss and counter expiry from every non-idle state.
    if (state_q != StIdle && !hpd_db_q) state_d = StIdle;

    // A new bring-up (idle) or a successful one (run) starts the retry tally over.
    if (state_d != state_q && (state_d == StIdle || state_d == StRun)) retry_d = '0;

    // Counter runs only in timed states and restarts on every transition.
    if (state_d == state_q) begin
      unique case (state_q)
        StPllRst, StWaitLock, StStable, StDivRel, StCoreRel: cnt_d = cnt_q + 1'b1;
        default:                                             cnt_d = '0;
      endcase
    end
  end

  // Output decode from the next state so outputs and state move on the same edge.
  always_comb begin
    pll_reset_d   = 1'b1;
    div_resetn_d  = 1'b0;
    core_resetn_d = 1'b0;
    tmds_oe_d     = 1'b0;
    link_up_d     = 1'b0;
    fault_d       = 1'b0;
    unique case (state_d)
      StIdle, StPllRst: begin
        pll_reset_d = 1'b1;
      end
      StWaitLock, StStable: begin
        pll_reset_d = 1'b0;
      end
      StDivRel: begin
        pll_reset_d  = 1'b0;
        div_resetn_d = 1'b1;
      end
      StCoreRel: begin
        pll_reset_d   = 1'b0;
        div_resetn_d  = 1'b1;
        core_resetn_d = 1'b1;
      end
      StRun: begin
        pll_reset_d   = 1'b0;
        div_resetn_d  = 1'b1;
        core_resetn_d = 1'b1;
        tmds_oe_d     = 1'b1;
        link_up_d     = 1'b1;
      end
      StFault: begin
        pll_reset_d = 1'b1;
        fault_d     = 1'b1;
      end
      default: begin
        pll_reset_d = 1'b1;
      end
    endcase
  end

  // State, counter, retry tally and registered outputs.
  always_ff @(posedge clk) begin
    if (!resetn) begin
      state_q     <= StIdle;
      cnt_q       <= '0;
      retry_q     <= '0;
      pll_reset   <= 1'b1;
      div_resetn  <= 1'b0;
      core_resetn <= 1'b0;
      tmds_oe     <= 1'b0;
      link_up     <= 1'b0;
      fault       <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      retry_q     <= retry_d;
      pll_reset   <= pll_reset_d;
      div_resetn  <= div_resetn_d;
      core_resetn <= core_resetn_d;
      tmds_oe     <= tmds_oe_d;
      link_up     <= link_up_d;
      fault       <= fault_d;
    end
  end

  assign retry_count = retry_q;
  assign state       = state_q;

endmodule
